inst_cache_sa: RTL and testbench

//   Parametrised set-associative instruction cache between IF stage (s_*) and AXI read master (m_*).

---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_data_array.sv | 30 +++
 rtl/inst_cache_sa.sv | 214 +++++++++++++++++++++
 tb/tb_inst_cache_sa.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, reset level and geometry width helpers for inst_cache_sa
package icache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESP, UNC_REQ, UNC_WAIT} state_e;
  localparam logic RST_ENABLE = 1'b0;
  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction
  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction
  function automatic int tag_w(input int num_sets, input int line_words);
    return 32 - off_w(line_words) - idx_w(num_sets);
  endfunction
endpackage

// File: rtl/icache_data_array.sv
// icache_data_array: NUM_SETS x NUM_WAYS x LINE_WORDS x 32 instruction storage
//   clk                          clock
//   we, w_set, w_way, w_word     synchronous write port (w_data)
//   r_set, r_way, r_word         asynchronous read port (r_data)
module icache_data_array
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 4,
  parameter int LINE_WORDS = 16,
  localparam int IW = idx_w(NUM_SETS),
  localparam int WW = off_w(LINE_WORDS) - 2,
  localparam int AW = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] w_set,
  input  logic [AW-1:0] w_way,
  input  logic [WW-1:0] w_word,
  input  logic [31:0]   w_data,
  input  logic [IW-1:0] r_set,
  input  logic [AW-1:0] r_way,
  input  logic [WW-1:0] r_word,
  output logic [31:0]   r_data
);
  logic [31:0] mem_q [NUM_SETS][NUM_WAYS][LINE_WORDS];
  always_ff @(posedge clk)
    if (we) mem_q[w_set][w_way][w_word] <= w_data;
  assign r_data = mem_q[r_set][r_way][r_word];
endmodule

// File: rtl/inst_cache_sa.sv
// inst_cache_sa: set-associative instruction cache, IF-stage slave (s_*) to AXI read master (m_*)
//   clk, rst (async, active-low)
//   cache_ena, inv                     cached/uncached select, whole-cache invalidate pulse
//   s_araddr/s_arvalid/s_arready       fetch request
//   s_rdata/s_rvalid                   fetch response (one-cycle pulse)
//   m_araddr/m_arlen/m_arvalid/m_arready, m_rdata/m_rlast/m_rvalid/m_rready   AXI read channels
// Optional macro ICACHE_EARLY_RESTART_EN: answer from the refill beat carrying the requested word.
module inst_cache_sa
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 4,
  parameter int LINE_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_ena,
  input  logic        inv,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic        s_rvalid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready
);
  localparam int OW = off_w(LINE_WORDS);
  localparam int IW = idx_w(NUM_SETS);
  localparam int TW = tag_w(NUM_SETS, LINE_WORDS);
  localparam int WW = OW - 2;
  localparam int AW = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
  state_e state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic inv_q, inv_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][TW-1:0] tag_q, tag_d;
  logic [NUM_SETS-1:0][AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] victim_q, victim_d;
  logic [WW-1:0] beat_q, beat_d;
  logic [31:0] s_rdata_q, s_rdata_d;
  logic s_rvalid_q, s_rvalid_d;
  logic m_arvalid_q, m_arvalid_d;
  logic [31:0] m_araddr_q, m_araddr_d;
  logic [7:0] m_arlen_q, m_arlen_d;
`ifdef ICACHE_EARLY_RESTART_EN
  logic early_q, early_d;
`endif
  logic [WW-1:0] req_word;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic hit, wr_en;
  logic [AW-1:0] hit_way, rd_way;
  logic [31:0] rd_data;
  assign req_word = addr_q[OW-1:2];
  assign req_idx = addr_q[OW+IW-1:OW];
  assign req_tag = addr_q[31:OW+IW];
  assign rd_way = state_q == LOOKUP ? hit_way : victim_q;
  assign s_arready = state_q == IDLE && !inv_q;
  assign s_rdata = s_rdata_q;
  assign s_rvalid = s_rvalid_q;
  assign m_araddr = m_araddr_q;
  assign m_arlen = m_arlen_q;
  assign m_arvalid = m_arvalid_q;
  assign m_rready = 1'b1;
  icache_data_array #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .LINE_WORDS(LINE_WORDS)) u_data (
    .clk(clk), .we(wr_en), .w_set(req_idx), .w_way(victim_q), .w_word(beat_q), .w_data(m_rdata),
    .r_set(req_idx), .r_way(rd_way), .r_word(req_word), .r_data(rd_data)
  );
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit = 1'b1;
        hit_way = AW'(w);
      end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    inv_d = inv_q | inv;
    valid_d = valid_q;
    tag_d = tag_q;
    ptr_d = ptr_q;
    victim_d = victim_q;
    beat_d = beat_q;
    s_rdata_d = s_rdata_q;
    s_rvalid_d = 1'b0;
    m_arvalid_d = m_arvalid_q;
    m_araddr_d = m_araddr_q;
    m_arlen_d = m_arlen_q;
    wr_en = 1'b0;
`ifdef ICACHE_EARLY_RESTART_EN
    early_d = early_q;
`endif
    case (state_q)
      IDLE:
        // A pending invalidate wins over a new fetch and blocks s_arready for this cycle.
        if (inv_q) begin
          valid_d = '0;
          ptr_d = '0;
          inv_d = inv;
        end else if (s_arvalid) begin
          addr_d = s_araddr[31:2];
          state_d = cache_ena ? LOOKUP : UNC_REQ;
          if (!cache_ena) begin
            m_arvalid_d = 1'b1;
            m_araddr_d = s_araddr;
            m_arlen_d = 8'd0;
          end
        end
      LOOKUP:
        if (hit) begin
          s_rvalid_d = 1'b1;
          s_rdata_d = rd_data;
          state_d = IDLE;
        end else begin
          m_arvalid_d = 1'b1;
          m_araddr_d = {addr_q[31:OW], {OW{1'b0}}};
          m_arlen_d = 8'(LINE_WORDS - 1);
          victim_d = ptr_q[req_idx];
          beat_d = '0;
          state_d = REFILL;
`ifdef ICACHE_EARLY_RESTART_EN
          early_d = 1'b0;
`endif
        end
      REFILL: begin
        if (m_arready) m_arvalid_d = 1'b0;
        if (m_rvalid) begin
          wr_en = 1'b1;
          beat_d = beat_q == WW'(LINE_WORDS - 1) ? beat_q : beat_q + 1'b1;
`ifdef ICACHE_EARLY_RESTART_EN
          if (!early_q && beat_q == req_word) begin
            s_rdata_d = m_rdata;
            s_rvalid_d = 1'b1;
            early_d = 1'b1;
          end
`endif
          // m_rlast closes the line even if the burst was shorter than expected.
          if (m_rlast) begin
            tag_d[req_idx][victim_q] = req_tag;
            valid_d[req_idx][victim_q] = 1'b1;
            ptr_d[req_idx] = victim_q == AW'(NUM_WAYS - 1) ? '0 : victim_q + 1'b1;
`ifdef ICACHE_EARLY_RESTART_EN
            state_d = early_d ? IDLE : RESP;
`else
            state_d = RESP;
`endif
          end
        end
      end
      RESP: begin
        s_rdata_d = rd_data;
        s_rvalid_d = 1'b1;
        state_d = IDLE;
      end
      UNC_REQ:
        if (m_arready) begin
          m_arvalid_d = 1'b0;
          state_d = UNC_WAIT;
        end
      UNC_WAIT:
        if (m_rvalid) begin
          s_rdata_d = m_rdata;
          s_rvalid_d = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (rst == RST_ENABLE) begin
      state_q <= IDLE;
      addr_q <= '0;
      inv_q <= 1'b0;
      valid_q <= '0;
      tag_q <= '0;
      ptr_q <= '0;
      victim_q <= '0;
      beat_q <= '0;
      s_rdata_q <= '0;
      s_rvalid_q <= 1'b0;
      m_arvalid_q <= 1'b0;
      m_araddr_q <= '0;
      m_arlen_q <= '0;
`ifdef ICACHE_EARLY_RESTART_EN
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      inv_q <= inv_d;
      valid_q <= valid_d;
      tag_q <= tag_d;
      ptr_q <= ptr_d;
      victim_q <= victim_d;
      beat_q <= beat_d;
      s_rdata_q <= s_rdata_d;
      s_rvalid_q <= s_rvalid_d;
      m_arvalid_q <= m_arvalid_d;
      m_araddr_q <= m_araddr_d;
      m_arlen_q <= m_arlen_d;
`ifdef ICACHE_EARLY_RESTART_EN
      early_q <= early_d;
`endif
    end
endmodule

// File: tb/tb_inst_cache_sa.sv
// tb_inst_cache_sa: directed self-checking bench for inst_cache_sa with an AXI read slave model
module tb_inst_cache_sa;
  logic clk = 1'b0, rst = 1'b0, cache_ena = 1'b0, inv = 1'b0;
  logic [31:0] s_araddr = '0, s_rdata, m_araddr, m_rdata = '0;
  logic s_arvalid = 1'b0, s_arready, s_rvalid, m_arvalid, m_arready = 1'b0;
  logic m_rlast = 1'b0, m_rvalid = 1'b0, m_rready;
  logic [7:0] m_arlen;
  int n_vec = 0, n_err = 0;
  logic f_ok, f_ar;
  logic [31:0] f_addr, f_rdata;
  logic [7:0] f_len;
  int f_cnt, f_lat, f_last;
  inst_cache_sa dut (
    .clk(clk), .rst(rst), .cache_ena(cache_ena), .inv(inv),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );
  always #5 clk = ~clk;
  // One fetch: slave grants AR in the first cycle m_arvalid is seen, then streams base+k per beat.
  // Cycle c counts from the acceptance cycle (c=0). Stops early at abort_beat (mid-burst).
  task automatic fetch(input logic [31:0] addr, input logic ena, input logic [31:0] base,
                       input int inv_beat, input int abort_beat);
    int k, phase;
    f_ok = 0; f_ar = 0; f_addr = 0; f_len = 0; f_rdata = 0; f_cnt = 0; f_lat = -1; f_last = -1;
    k = 0; phase = 0;
    for (int i = 0; i < 20 && !s_arready; i++) @(negedge clk);
    if (!s_arready) return;
    s_araddr = addr; cache_ena = ena; s_arvalid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      s_arvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; inv = 1'b0;
      if (s_rvalid) begin f_cnt++; f_rdata = s_rdata; f_lat = c; end
      if (phase == 0 && m_arvalid) begin
        f_ar = 1; f_addr = m_araddr; f_len = m_arlen; m_arready = 1'b1; phase = 1;
      end else if (phase == 1) begin
        if (k == abort_beat) begin f_ok = 1; return; end
        m_rvalid = 1'b1; m_rdata = base + k; m_rlast = (k == int'(f_len)); inv = (k == inv_beat);
        f_last = c;
        if (m_rlast) phase = 2;
        k++;
      end
      if (f_cnt > 0 && phase != 1 && c >= f_lat + 3) begin f_ok = 1; return; end
    end
  endtask
  task automatic test_reset;
    n_vec++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_s_rvalid got %b want 0", s_rvalid); end
    n_vec++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL reset_m_arvalid got %b want 0", m_arvalid); end
    n_vec++; if (m_araddr !== 32'h0) begin n_err++; $display("FAIL reset_m_araddr got %h want 0", m_araddr); end
    n_vec++; if (m_arlen !== 8'h0) begin n_err++; $display("FAIL reset_m_arlen got %h want 0", m_arlen); end
    n_vec++; if (s_rdata !== 32'h0) begin n_err++; $display("FAIL reset_s_rdata got %h want 0", s_rdata); end
    n_vec++; if (s_arready !== 1'b1) begin n_err++; $display("FAIL reset_s_arready got %b want 1", s_arready); end
    n_vec++; if (m_rready !== 1'b1) begin n_err++; $display("FAIL reset_m_rready got %b want 1", m_rready); end
  endtask
  task automatic test_cold_miss;
    fetch(32'h1FC0_0004, 1'b1, 32'hA0, -1, -1);
    n_vec++; if (f_ok !== 1'b1) begin n_err++; $display("FAIL cold_done got %b want 1", f_ok); end
    n_vec++; if (f_addr !== 32'h1FC0_0000) begin n_err++; $display("FAIL cold_araddr got %h want 1fc00000", f_addr); end
    n_vec++; if (f_len !== 8'd15) begin n_err++; $display("FAIL cold_arlen got %0d want 15", f_len); end
    n_vec++; if (f_rdata !== 32'hA1) begin n_err++; $display("FAIL cold_rdata got %h want a1", f_rdata); end
    n_vec++; if (f_cnt !== 1) begin n_err++; $display("FAIL cold_pulses got %0d want 1", f_cnt); end
    n_vec++; if (f_lat !== f_last + 2) begin n_err++; $display("FAIL cold_latency got %0d want %0d", f_lat, f_last + 2); end
  endtask
  task automatic test_hit;
    fetch(32'h1FC0_0008, 1'b1, 32'h0, -1, -1);
    n_vec++; if (f_ar !== 1'b0) begin n_err++; $display("FAIL hit_no_ar got %b want 0", f_ar); end
    n_vec++; if (f_rdata !== 32'hA2) begin n_err++; $display("FAIL hit_rdata got %h want a2", f_rdata); end
    n_vec++; if (f_lat !== 2) begin n_err++; $display("FAIL hit_latency got %0d want 2", f_lat); end
    n_vec++; if (f_cnt !== 1) begin n_err++; $display("FAIL hit_pulses got %0d want 1", f_cnt); end
  endtask
  task automatic test_replacement;
    for (int i = 0; i < 4; i++) begin
      fetch(32'h2000_0000 + 32'(i) * 32'h100, 1'b1, 32'h100 * (i + 1), -1, -1);
      n_vec++; if (f_ar !== 1'b1) begin n_err++; $display("FAIL repl_fill%0d_ar got %b want 1", i, f_ar); end
      n_vec++; if (f_rdata !== 32'h100 * (i + 1)) begin n_err++; $display("FAIL repl_fill%0d_rdata got %h want %h", i, f_rdata, 32'h100 * (i + 1)); end
    end
    fetch(32'h2000_0104, 1'b1, 32'h0, -1, -1);
    n_vec++; if (f_ar !== 1'b0) begin n_err++; $display("FAIL repl_keep_ar got %b want 0", f_ar); end
    n_vec++; if (f_rdata !== 32'h201) begin n_err++; $display("FAIL repl_keep_rdata got %h want 201", f_rdata); end
    fetch(32'h1FC0_0008, 1'b1, 32'hA0, -1, -1);
    n_vec++; if (f_ar !== 1'b1) begin n_err++; $display("FAIL repl_evicted_ar got %b want 1", f_ar); end
    n_vec++; if (f_rdata !== 32'hA2) begin n_err++; $display("FAIL repl_evicted_rdata got %h want a2", f_rdata); end
  endtask
  task automatic test_uncached;
    fetch(32'hBFC0_0010, 1'b0, 32'hDEAD_BEEF, -1, -1);
    n_vec++; if (f_addr !== 32'hBFC0_0010) begin n_err++; $display("FAIL unc_araddr got %h want bfc00010", f_addr); end
    n_vec++; if (f_len !== 8'd0) begin n_err++; $display("FAIL unc_arlen got %0d want 0", f_len); end
    n_vec++; if (f_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL unc_rdata got %h want deadbeef", f_rdata); end
    n_vec++; if (f_lat !== f_last + 1) begin n_err++; $display("FAIL unc_latency got %0d want %0d", f_lat, f_last + 1); end
    fetch(32'hBFC0_0010, 1'b1, 32'hC0, -1, -1);
    n_vec++; if (f_ar !== 1'b1) begin n_err++; $display("FAIL unc_then_cached_ar got %b want 1", f_ar); end
    n_vec++; if (f_addr !== 32'hBFC0_0000) begin n_err++; $display("FAIL unc_then_cached_araddr got %h want bfc00000", f_addr); end
    n_vec++; if (f_rdata !== 32'hC4) begin n_err++; $display("FAIL unc_then_cached_rdata got %h want c4", f_rdata); end
  endtask
  task automatic test_inv_idle;
    inv = 1'b1;
    @(negedge clk); inv = 1'b0;
    n_vec++; if (s_arready !== 1'b0) begin n_err++; $display("FAIL inv_idle_block got %b want 0", s_arready); end
    @(negedge clk);
    n_vec++; if (s_arready !== 1'b1) begin n_err++; $display("FAIL inv_idle_release got %b want 1", s_arready); end
    fetch(32'hBFC0_0014, 1'b1, 32'hC0, -1, -1);
    n_vec++; if (f_ar !== 1'b1) begin n_err++; $display("FAIL inv_idle_miss got %b want 1", f_ar); end
  endtask
  task automatic test_inv_refill;
    fetch(32'h4000_0044, 1'b1, 32'hE0, 3, -1);
    n_vec++; if (f_rdata !== 32'hE1) begin n_err++; $display("FAIL invr_rdata got %h want e1", f_rdata); end
    n_vec++; if (f_cnt !== 1) begin n_err++; $display("FAIL invr_pulses got %0d want 1", f_cnt); end
    fetch(32'h4000_0044, 1'b1, 32'hE0, -1, -1);
    n_vec++; if (f_ar !== 1'b1) begin n_err++; $display("FAIL invr_same_line_ar got %b want 1", f_ar); end
    n_vec++; if (f_rdata !== 32'hE1) begin n_err++; $display("FAIL invr_same_line_rdata got %h want e1", f_rdata); end
  endtask
  task automatic test_reset_mid_burst;
    fetch(32'h5000_0000, 1'b1, 32'h10, -1, 7);
    n_vec++; if (s_arready !== 1'b0) begin n_err++; $display("FAIL rstb_busy got %b want 0", s_arready); end
    rst = 1'b0;
    #1;
    n_vec++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL rstb_s_rvalid got %b want 0", s_rvalid); end
    n_vec++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL rstb_m_arvalid got %b want 0", m_arvalid); end
    n_vec++; if (s_arready !== 1'b1) begin n_err++; $display("FAIL rstb_idle got %b want 1", s_arready); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    fetch(32'h4000_0044, 1'b1, 32'hE0, -1, -1);
    n_vec++; if (f_ar !== 1'b1) begin n_err++; $display("FAIL rstb_post_miss got %b want 1", f_ar); end
    n_vec++; if (f_rdata !== 32'hE1) begin n_err++; $display("FAIL rstb_post_rdata got %h want e1", f_rdata); end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset;
    test_cold_miss;
    test_hit;
    test_replacement;
    test_uncached;
    test_inv_idle;
    test_inv_refill;
    test_reset_mid_burst;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
